bcd_stopwatch: RTL and testbench
================================

// Module: bcd_stopwatch
// PURPOSE
//  Parametrised N-digit BCD stopwatch/timer core with run/stop, clear, lap-hold,
//  up/down count and preload. Drives the 4-bit digit inputs of the seven-segment
//  display multiplexer. Replaces the fixed 4-digit count block in the display top.
//  Button inputs arrive already debounced and edge-detected as 1-cycle pulses.
// PARAMETERS
//  N_DIGITS  4        number of BCD digits (1..8); digit 0 is least significant
//  TICK_DIV  1000000  clk cycles per count step (>=2); 100 MHz -> 0.01 s step
// PORTS
//  clk         in   1           system clock, all state on rising edge
//  rst_n       in   1           reset, asynchronous, active-low
//  start_stop  in   1           pulse: toggle running
//  clear       in   1           pulse: count=0, stop, release lap, prescaler=0
//  lap         in   1           pulse: toggle lap hold (freeze displayed value)
//  dir         in   1           0 = count up, 1 = count down; sampled at each step
//  load        in   1           pulse: preload count from load_val (stopped only)
//  load_val    in   4*N_DIGITS  BCD preload value, digit i at [4i+3:4i]
//  digits      out  4*N_DIGITS  display value: lap_value if lap_active, else count
//  count       out  4*N_DIGITS  live BCD count
//  running     out  1           1 while in RUN state
//  lap_active  out  1           1 while display is frozen
//  wrap        out  1           1-cycle pulse: up-count rolled all-9s -> 0
//  done        out  1           1-cycle pulse: down-count reached 0 and stopped
// BEHAVIOUR
//  Reset (async, rst_n=0): count=0, lap_value=0, prescaler=0, state=STOPPED,
//   running=0, lap_active=0, wrap=0, done=0, digits=0. All outputs registered.
//  FSM: STOPPED --start_stop--> RUN; RUN --start_stop--> STOPPED;
//   RUN --down step reaching 0--> STOPPED; any state --clear--> STOPPED.
//  Prescaler: counts 0..TICK_DIV-1 only in RUN; holds value in STOPPED (resume
//   keeps fractional step); zeroed by clear and by accepted load.
//  Step: in RUN when prescaler==TICK_DIV-1; count updates at that same edge.
//   Up: BCD increment with per-digit carry (9->0, carry to next digit);
//    all-9s -> all-0s, wrap=1 for one cycle, keeps running.
//   Down: BCD decrement with per-digit borrow (0->9). Result 0 -> running=0,
//    done=1 one cycle. Step at count==0 (started at 0): count stays 0,
//    done=1, stop. Down-count never wraps.
//  Priority in one cycle: clear > load > start_stop/step > lap.
//   clear + anything: clear only; wrap/done not asserted.
//   load: accepted only in STOPPED; ignored in RUN. Digits >9 in load_val
//    clamp to 9. Lap state unaffected.
//   start_stop in same cycle as step: step applies (old state was RUN), then
//    stop takes effect; done from the step still pulses.
//  Lap: pulse with lap_active=0 captures count (value before any same-cycle
//   step) into lap_value, lap_active=1; pulse with lap_active=1 releases.
//   Allowed in both states; counting continues underneath.
//  digits mux is registered: reflects count/lap_value one cycle after update.
//  dir change mid-run takes effect at next step; prescaler not disturbed.
// TESTING (N_DIGITS=2, TICK_DIV=4 unless noted)
//  1 reset, start_stop, 40 clk -> count=8'h10 after 10 steps; running=1;
//    steps exactly every 4 clk; start_stop at count 8'h10 -> stops, holds.
//  2 load 8'h98 stopped, dir=0, run -> 98,99,00 with wrap=1 for exactly 1 clk,
//    then 01; load during RUN ignored.
//  3 load 8'h02, dir=1, run -> 01,00; done=1 one clk, running=0 same edge;
//    start_stop again at 00 -> one step later done=1, count stays 00, stops.
//  4 lap at count 8'h05 -> digits frozen at 05 while count reaches 09;
//    lap again -> digits follow count next clk; clear -> all 0, lap_active=0.
//  5 clear and start_stop same cycle while stopped -> stays STOPPED, count=0;
//    rst_n low mid-run (async, off clock edge) -> outputs 0 immediately.
//  6 load_val 8'hFA -> count=8'h99 (clamped); N_DIGITS=4 up from 9999 -> 0000 + wrap.

Source files
------------

// File: rtl/bcd_stopwatch.sv
// N-digit BCD stopwatch/timer core: run/stop, clear, lap hold, up/down count
// and preload. Feeds the 4-bit digit inputs of the seven-segment multiplexer.
// Button inputs are expected as debounced single-cycle pulses.
module bcd_stopwatch #(
  parameter int N_DIGITS = 4,
  parameter int TICK_DIV = 1000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_stop,
  input  logic                  clear,
  input  logic                  lap,
  input  logic                  dir,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] load_val,
  output logic [4*N_DIGITS-1:0] digits,
  output logic [4*N_DIGITS-1:0] count,
  output logic                  running,
  output logic                  lap_active,
  output logic                  wrap,
  output logic                  done
);

  localparam int W  = 4 * N_DIGITS;
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic {
    ST_STOPPED = 1'b0,
    ST_RUN     = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    count_q, count_d;
  logic [W-1:0]    lap_q, lap_d;
  logic            lap_active_q, lap_active_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            wrap_q, wrap_d;
  logic            done_q, done_d;
  logic [W-1:0]    digits_q;

  // BCD increment with ripple carry; all-9s rolls over to all-0s.
  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (carry) begin
        if (v[4*i +: 4] >= 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // BCD decrement with ripple borrow; caller never passes zero.
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Non-BCD preload digits saturate to 9 so the count stays valid BCD.
  function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
    end
    return r;
  endfunction

  // Next-state logic: clear > load > start_stop/step; lap handled alongside.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d      = state_q;
    count_d      = count_q;
    lap_d        = lap_q;
    lap_active_d = lap_active_q;
    presc_d      = presc_q;
    wrap_d       = 1'b0;
    done_d       = 1'b0;

    if (clear) begin
      state_d      = ST_STOPPED;
      count_d      = '0;
      lap_d        = '0;
      lap_active_d = 1'b0;
      presc_d      = '0;
    end else begin
      if (load && state_q == ST_STOPPED) begin
        count_d = bcd_clamp(load_val);
        presc_d = '0;
      end else if (state_q == ST_RUN) begin
        if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          if (!dir) begin
            count_d = bcd_inc(count_q);
            wrap_d  = (count_d == '0);
          end else if (count_q == '0) begin
            done_d  = 1'b1;
            state_d = ST_STOPPED;
          end else begin
            count_d = bcd_dec(count_q);
            if (count_d == '0) begin
              done_d  = 1'b1;
              state_d = ST_STOPPED;
            end
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
        if (start_stop) state_d = ST_STOPPED;
      end else if (start_stop) begin
        state_d = ST_RUN;
      end

      // Lap captures the pre-step count so the frozen value matches the display.
      if (lap) begin
        if (lap_active_q) begin
          lap_active_d = 1'b0;
        end else begin
          lap_active_d = 1'b1;
          lap_d        = count_q;
        end
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_STOPPED;
      count_q      <= '0;
      lap_q        <= '0;
      lap_active_q <= 1'b0;
      presc_q      <= '0;
      wrap_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q      <= state_d;
      count_q      <= count_d;
      lap_q        <= lap_d;
      lap_active_q <= lap_active_d;
      presc_q      <= presc_d;
      wrap_q       <= wrap_d;
      done_q       <= done_d;
    end
  end

  // Registered display mux: shows the frozen lap value or the live count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_q <= '0;
    end else begin
      digits_q <= lap_active_q ? lap_q : count_q;
    end
  end

  assign digits     = digits_q;
  assign count      = count_q;
  assign running    = (state_q == ST_RUN);
  assign lap_active = lap_active_q;
  assign wrap       = wrap_q;
  assign done       = done_q;

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Directed bench for bcd_stopwatch: a 2-digit instance for the main behaviour
// and a 4-digit instance for the full-width rollover.
module tb_bcd_stopwatch;

  logic        clk;
  logic        rst_n;
  logic        start_stop, clear, lap, dir, load;
  logic [7:0]  load_val;
  logic [7:0]  digits, count;
  logic        running, lap_active, wrap, done;

  logic        b_start_stop, b_clear, b_lap, b_dir, b_load;
  logic [15:0] b_load_val;
  logic [15:0] b_digits, b_count;
  logic        b_running, b_lap_active, b_wrap, b_done;

  bcd_stopwatch #(.N_DIGITS(2), .TICK_DIV(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .start_stop(start_stop), .clear(clear),
    .lap(lap), .dir(dir), .load(load), .load_val(load_val),
    .digits(digits), .count(count), .running(running),
    .lap_active(lap_active), .wrap(wrap), .done(done)
  );

  bcd_stopwatch #(.N_DIGITS(4), .TICK_DIV(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start_stop(b_start_stop), .clear(b_clear),
    .lap(b_lap), .dir(b_dir), .load(b_load), .load_val(b_load_val),
    .digits(b_digits), .count(b_count), .running(b_running),
    .lap_active(b_lap_active), .wrap(b_wrap), .done(b_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic expect_val(input string tag, input logic [15:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic check(input logic [15:0] obs);
    exp_t e;
    n_checks++;
    if (sb_q.size() == 0) begin
      n_errors++;
      $error("FAIL scoreboard_empty: observed %h, no expected value queued", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val) else begin
        n_errors++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start_stop = 0; clear = 0; lap = 0; dir = 0; load = 0; load_val = '0;
    b_start_stop = 0; b_clear = 0; b_lap = 0; b_dir = 0; b_load = 0; b_load_val = '0;

    // Reset state
    #12;
    expect_val("rst_count", 16'h0);   check(16'(count));
    expect_val("rst_digits", 16'h0);  check(16'(digits));
    expect_val("rst_running", 16'h0); check(16'(running));
    expect_val("rst_lap", 16'h0);     check(16'(lap_active));
    expect_val("rst_wrap", 16'h0);    check(16'(wrap));
    expect_val("rst_done", 16'h0);    check(16'(done));
    #1 rst_n = 1'b1;

    // 1: count up, one step every 4 clocks, stop holds
    start_stop = 1; tick(1); start_stop = 0;
    expect_val("t1_cnt_pre", 16'h00); expect_val("t1_run", 16'h1);
    tick(3); check(16'(count)); check(16'(running));
    expect_val("t1_cnt_first", 16'h01);
    tick(1); check(16'(count));
    expect_val("t1_cnt_10", 16'h10); expect_val("t1_dig_lag", 16'h09);
    tick(36); check(16'(count)); check(16'(digits));
    start_stop = 1; tick(1); start_stop = 0;
    expect_val("t1_stopped", 16'h0); expect_val("t1_dig_10", 16'h10);
    check(16'(running)); check(16'(digits));
    expect_val("t1_hold", 16'h10);
    tick(10); check(16'(count));

    // 2: preload 98, count through wrap; load while running ignored
    load_val = 8'h98; load = 1; tick(1); load = 0;
    expect_val("t2_load", 16'h98); check(16'(count));
    dir = 0; start_stop = 1; tick(1); start_stop = 0;
    expect_val("t2_99", 16'h99); tick(4); check(16'(count));
    expect_val("t2_00", 16'h00); expect_val("t2_wrap1", 16'h1);
    tick(4); check(16'(count)); check(16'(wrap));
    expect_val("t2_wrap0", 16'h0); tick(1); check(16'(wrap));
    load_val = 8'h55; load = 1; tick(1); load = 0;
    expect_val("t2_load_ign", 16'h00); tick(1); check(16'(count));
    expect_val("t2_01", 16'h01); tick(1); check(16'(count));
    start_stop = 1; tick(1); start_stop = 0;

    // 3: count down to zero, then a step started at zero
    load_val = 8'h02; load = 1; tick(1); load = 0;
    dir = 1; start_stop = 1; tick(1); start_stop = 0;
    expect_val("t3_01", 16'h01); tick(4); check(16'(count));
    expect_val("t3_pre_done", 16'h0); tick(3); check(16'(done));
    expect_val("t3_00", 16'h00); expect_val("t3_done", 16'h1); expect_val("t3_stop", 16'h0);
    tick(1); check(16'(count)); check(16'(done)); check(16'(running));
    expect_val("t3_done_pulse", 16'h0); tick(1); check(16'(done));
    start_stop = 1; tick(1); start_stop = 0;
    expect_val("t3_run0", 16'h1); tick(3); check(16'(running));
    expect_val("t3_done0", 16'h1); expect_val("t3_stop0", 16'h0); expect_val("t3_cnt0", 16'h00);
    tick(1); check(16'(done)); check(16'(running)); check(16'(count));

    // 4: lap freeze and release, then clear
    clear = 1; tick(1); clear = 0;
    dir = 0; start_stop = 1; tick(1); start_stop = 0;
    tick(20);
    expect_val("t4_05", 16'h05); check(16'(count));
    lap = 1; tick(1); lap = 0;
    expect_val("t4_lap_on", 16'h1); check(16'(lap_active));
    expect_val("t4_cnt_09", 16'h09); expect_val("t4_dig_frozen", 16'h05);
    tick(15); check(16'(count)); check(16'(digits));
    lap = 1; tick(1); lap = 0;
    expect_val("t4_lap_off", 16'h0); check(16'(lap_active));
    expect_val("t4_dig_follow", 16'h09); tick(1); check(16'(digits));
    clear = 1; tick(1); clear = 0;
    expect_val("t4_clr_cnt", 16'h00); expect_val("t4_clr_run", 16'h0);
    check(16'(count)); check(16'(running));
    expect_val("t4_clr_dig", 16'h00); tick(1); check(16'(digits));

    // 5: clear beats start_stop; async reset mid-run
    clear = 1; start_stop = 1; tick(1); clear = 0; start_stop = 0;
    expect_val("t5_stay_stop", 16'h0); check(16'(running));
    start_stop = 1; tick(1); start_stop = 0;
    expect_val("t5_dig_pre", 16'h01); tick(5); check(16'(digits));
    #2 rst_n = 1'b0;
    #1;
    expect_val("t5_arst_cnt", 16'h0); expect_val("t5_arst_dig", 16'h0); expect_val("t5_arst_run", 16'h0);
    check(16'(count)); check(16'(digits)); check(16'(running));
    #2 rst_n = 1'b1;
    tick(1);

    // 6: clamped preload; 4-digit rollover
    dir = 0; load_val = 8'hFA; load = 1; tick(1); load = 0;
    expect_val("t6_clamp", 16'h99); check(16'(count));
    b_load_val = 16'h9999; b_load = 1; tick(1); b_load = 0;
    b_start_stop = 1; tick(1); b_start_stop = 0;
    expect_val("t6_b_9999", 16'h9999); expect_val("t6_b_nowrap", 16'h0);
    tick(3); check(b_count); check(16'(b_wrap));
    expect_val("t6_b_0000", 16'h0000); expect_val("t6_b_wrap", 16'h1); expect_val("t6_b_run", 16'h1);
    tick(1); check(b_count); check(16'(b_wrap)); check(16'(b_running));
    expect_val("t6_b_wrap_end", 16'h0); tick(1); check(16'(b_wrap));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
